ds1302_rtc_ctrl: RTL and testbench

- Transaction sequencer that sits directly upstream of the DS1302 register read/write engine.
- Periodically sweeps the seven DS1302 time registers: seconds, minutes, hours, date, month, day-of-week, year.
- Presents a coherent BCD time snapshot to the display/application logic.
- On request, performs a full time-set sequence bracketed by write-protect off/on, issuing one engine transaction (cmd/ack handshake) per register.

---
 rtl/ds1302_rtc_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_ds1302_rtc_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ds1302_rtc_ctrl.sv
// DS1302 transaction sequencer: periodic 7-register time sweep plus a
// write-protect-bracketed time-set sequence, one engine handshake per register.
module ds1302_rtc_ctrl #(
  parameter logic [23:0] READ_INTERVAL = 24'd5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       write_time_req,
  input  logic [7:0] write_second,
  input  logic [7:0] write_minute,
  input  logic [7:0] write_hour,
  input  logic [7:0] write_date,
  input  logic [7:0] write_month,
  input  logic [7:0] write_week,
  input  logic [7:0] write_year,
  output logic       write_time_ack,
  output logic [7:0] read_second,
  output logic [7:0] read_minute,
  output logic [7:0] read_hour,
  output logic [7:0] read_date,
  output logic [7:0] read_month,
  output logic [7:0] read_week,
  output logic [7:0] read_year,
  output logic       time_valid,
  output logic       busy,
  output logic       cmd_read,
  output logic       cmd_write,
  input  logic       cmd_read_ack,
  input  logic       cmd_write_ack,
  output logic [7:0] read_addr,
  output logic [7:0] write_addr,
  output logic [7:0] write_data,
  input  logic [7:0] read_data
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_WAIT} state_t;

  state_t      state, state_n;
  logic [3:0]  idx, idx_n;
  logic [23:0] wait_cnt, wait_n;
  logic        pending, pending_n;
  logic        cmd_read_n, cmd_write_n, ack_n, valid_n;
  logic [7:0]  raddr_n, waddr_n, wdata_n;
  logic        req_take, cap, publish;
  logic [7:0]  wsh [7];
  logic [7:0]  rsh [7];

  assign req_take = write_time_req && !pending && (state != S_WRITE);
  assign busy     = pending;

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    wait_n      = wait_cnt;
    pending_n   = pending | req_take;
    cmd_read_n  = cmd_read;
    cmd_write_n = cmd_write;
    raddr_n     = read_addr;
    waddr_n     = write_addr;
    wdata_n     = write_data;
    ack_n       = 1'b0;
    valid_n     = 1'b0;
    cap         = 1'b0;
    publish     = 1'b0;
    case (state)
      S_IDLE: begin
        idx_n   = '0;
        state_n = pending ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        if (!cmd_write) begin
          cmd_write_n = 1'b1;
          case (idx)
            4'd0:    begin waddr_n = 8'h8E; wdata_n = 8'h00; end
            4'd1:    begin waddr_n = 8'h80; wdata_n = {1'b0, wsh[0][6:0]}; end
            4'd8:    begin waddr_n = 8'h8E; wdata_n = 8'h80; end
            default: begin
              waddr_n = 8'h7E + {3'b000, idx, 1'b0};
              wdata_n = wsh[3'(idx - 4'd1)];
            end
          endcase
        end else if (cmd_write_ack) begin
          cmd_write_n = 1'b0;
          if (idx == 4'd8) begin
            ack_n     = 1'b1;
            pending_n = 1'b0;
            idx_n     = '0;
            wait_n    = '0;
            state_n   = S_WAIT;
          end else begin
            idx_n = idx + 4'd1;
          end
        end
      end
      S_READ: begin
        if (!cmd_read) begin
          cmd_read_n = 1'b1;
          raddr_n    = 8'h81 + {3'b000, idx, 1'b0};
        end else if (cmd_read_ack) begin
          cmd_read_n = 1'b0;
          cap        = 1'b1;
          if (idx == 4'd6) begin
            publish = 1'b1;
            valid_n = 1'b1;
            idx_n   = '0;
            wait_n  = '0;
            state_n = (pending || req_take) ? S_IDLE : S_WAIT;
          end else begin
            idx_n = idx + 4'd1;
          end
        end
      end
      S_WAIT: begin
        // A pending write (including one latched as the sweep ended) cuts the wait short.
        if (pending || req_take || (wait_cnt == READ_INTERVAL - 24'd1)) begin
          state_n = S_IDLE;
        end else begin
          wait_n = wait_cnt + 24'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      wait_cnt       <= '0;
      pending        <= 1'b0;
      cmd_read       <= 1'b0;
      cmd_write      <= 1'b0;
      read_addr      <= '0;
      write_addr     <= '0;
      write_data     <= '0;
      write_time_ack <= 1'b0;
      time_valid     <= 1'b0;
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      wait_cnt       <= wait_n;
      pending        <= pending_n;
      cmd_read       <= cmd_read_n;
      cmd_write      <= cmd_write_n;
      read_addr      <= raddr_n;
      write_addr     <= waddr_n;
      write_data     <= wdata_n;
      write_time_ack <= ack_n;
      time_valid     <= valid_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 7; i++) begin
        wsh[i] <= '0;
        rsh[i] <= '0;
      end
      read_second <= '0;
      read_minute <= '0;
      read_hour   <= '0;
      read_date   <= '0;
      read_month  <= '0;
      read_week   <= '0;
      read_year   <= '0;
    end else begin
      if (req_take) begin
        wsh[0] <= write_second;
        wsh[1] <= write_minute;
        wsh[2] <= write_hour;
        wsh[3] <= write_date;
        wsh[4] <= write_month;
        wsh[5] <= write_week;
        wsh[6] <= write_year;
      end
      if (cap) begin
        rsh[3'(idx)] <= (idx == 4'd0) ? {1'b0, read_data[6:0]} : read_data;
      end
      // Year arrives in the publish cycle itself, so it bypasses its shadow.
      if (publish) begin
        read_second <= rsh[0];
        read_minute <= rsh[1];
        read_hour   <= rsh[2];
        read_date   <= rsh[3];
        read_month  <= rsh[4];
        read_week   <= rsh[5];
        read_year   <= read_data;
      end
    end
  end

endmodule

// File: tb/tb_ds1302_rtc_ctrl.sv
// Self-checking bench for ds1302_rtc_ctrl: engine model with programmable ack
// latency, scoreboards for write pairs, snapshots and write acks.
`timescale 1ns/1ps
module tb_ds1302_rtc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       write_time_req;
  logic [7:0] write_second, write_minute, write_hour, write_date;
  logic [7:0] write_month, write_week, write_year;
  logic       write_time_ack;
  logic [7:0] read_second, read_minute, read_hour, read_date;
  logic [7:0] read_month, read_week, read_year;
  logic       time_valid, busy, cmd_read, cmd_write;
  logic       cmd_read_ack, cmd_write_ack;
  logic [7:0] read_addr, write_addr, write_data, read_data;

  ds1302_rtc_ctrl #(.READ_INTERVAL(24'd1000)) dut (
    .clk(clk), .rst(rst), .write_time_req(write_time_req),
    .write_second(write_second), .write_minute(write_minute), .write_hour(write_hour),
    .write_date(write_date), .write_month(write_month), .write_week(write_week),
    .write_year(write_year), .write_time_ack(write_time_ack),
    .read_second(read_second), .read_minute(read_minute), .read_hour(read_hour),
    .read_date(read_date), .read_month(read_month), .read_week(read_week),
    .read_year(read_year), .time_valid(time_valid), .busy(busy),
    .cmd_read(cmd_read), .cmd_write(cmd_write), .cmd_read_ack(cmd_read_ack),
    .cmd_write_ack(cmd_write_ack), .read_addr(read_addr), .write_addr(write_addr),
    .write_data(write_data), .read_data(read_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  logic [15:0] wr_q [$];
  logic [55:0] snap_q [$];
  int          ack_q [$];
  logic [7:0]  rd_vals [7];
  logic [7:0]  ret [7];
  int  ack_delay = 300;
  int  eng_rd_idx = 0, eng_wr_idx = 0;
  int  tv_cnt = 0, ack_cnt = 0, tv_cyc = 0;
  bit  gap_armed = 0, lat_armed = 0, viol = 0;

  // Engine model plus output monitors, all sampled on the falling edge.
  initial begin
    int  rd_cnt, wr_cnt, hold_r, hold_w, lat_r, lat_w;
    bit  prev_r, prev_w;
    cmd_read_ack = 0; cmd_write_ack = 0; read_data = 0;
    prev_r = 0; prev_w = 0; rd_cnt = 0; wr_cnt = 0;
    hold_r = 0; hold_w = 0; lat_r = 0; lat_w = 0;
    forever begin
      @(negedge clk);
      cmd_read_ack = 0;
      cmd_write_ack = 0;
      if (!rst) begin
        eng_rd_idx = 0; eng_wr_idx = 0; prev_r = 0; prev_w = 0;
        gap_armed = 0; lat_armed = 0;
      end else begin
        if (cmd_read && cmd_write) viol = 1;
        if (time_valid) begin
          tv_cnt++;
          tv_cyc = cyc;
          if (snap_q.size() == 0) check("tv_extra", 0, 1);
          else check("snapshot", {read_second, read_minute, read_hour, read_date,
                                  read_month, read_week, read_year}, snap_q.pop_front());
          gap_armed = !busy;
          lat_armed = busy;
        end
        if (write_time_ack) begin
          ack_cnt++;
          if (ack_q.size() == 0) check("ack_extra", 0, 1);
          else begin
            void'(ack_q.pop_front());
            check("ack_busy_clear", busy, 0);
            check("ack_pairs_done", wr_q.size(), 0);
          end
        end
        if (cmd_read) begin
          if (!prev_r) begin
            check("rd_addr", read_addr, 8'h81 + 8'(2 * eng_rd_idx));
            if (gap_armed) begin
              check("sweep_gap", cyc - tv_cyc, 1002);
              gap_armed = 0;
            end
            rd_cnt = ack_delay - 1; lat_r = ack_delay; hold_r = 0;
          end else rd_cnt--;
          hold_r++;
          if (rd_cnt == 0) begin
            read_data = rd_vals[eng_rd_idx];
            ret[eng_rd_idx] = read_data;
            cmd_read_ack = 1;
            if (eng_rd_idx == 6) begin
              snap_q.push_back({ret[0] & 8'h7F, ret[1], ret[2], ret[3], ret[4], ret[5], ret[6]});
              eng_rd_idx = 0;
            end else eng_rd_idx++;
          end
        end else if (prev_r) check("rd_hold", hold_r, lat_r);
        if (cmd_write) begin
          if (!prev_w) begin
            if (wr_q.size() == 0) check("wr_extra", 0, 1);
            else check("wr_pair", {write_addr, write_data}, wr_q.pop_front());
            check("busy_in_write", busy, 1);
            if (lat_armed) begin
              check("wr_after_sweep", (cyc - tv_cyc) <= 3, 1);
              lat_armed = 0;
            end
            gap_armed = 0;
            wr_cnt = ack_delay - 1; lat_w = ack_delay; hold_w = 0;
          end else wr_cnt--;
          hold_w++;
          if (wr_cnt == 0) begin
            cmd_write_ack = 1;
            eng_wr_idx = (eng_wr_idx == 8) ? 0 : eng_wr_idx + 1;
          end
        end else if (prev_w) check("wr_hold", hold_w, lat_w);
        prev_r = cmd_read;
        prev_w = cmd_write;
      end
    end
  end

  task automatic drive_write(input logic [7:0] s, m, h, d, mo, w, y, input bit accept);
    @(negedge clk);
    write_second = s; write_minute = m; write_hour = h; write_date = d;
    write_month = mo; write_week = w; write_year = y;
    write_time_req = 1;
    if (accept) begin
      wr_q.push_back({8'h8E, 8'h00});
      wr_q.push_back({8'h80, 1'b0, s[6:0]});
      wr_q.push_back({8'h82, m});
      wr_q.push_back({8'h84, h});
      wr_q.push_back({8'h86, d});
      wr_q.push_back({8'h88, mo});
      wr_q.push_back({8'h8A, w});
      wr_q.push_back({8'h8C, y});
      wr_q.push_back({8'h8E, 8'h80});
      ack_q.push_back(1);
    end
    @(negedge clk);
    write_time_req = 0;
  endtask

  task automatic wait_tv(input int n, input int budget);
    int start = tv_cnt;
    for (int i = 0; i < budget && tv_cnt < start + n; i++) @(negedge clk);
    check("tv_timeout", tv_cnt >= start + n, 1);
  endtask

  task automatic wait_ack(input int budget);
    int start = ack_cnt;
    for (int i = 0; i < budget && ack_cnt == start; i++) @(negedge clk);
    check("ack_timeout", ack_cnt > start, 1);
  endtask

  task automatic wait_wr_idx(input int k, input int budget);
    int i;
    for (i = 0; i < budget && !(cmd_write && eng_wr_idx == k); i++) @(negedge clk);
    check("wr_idx_timeout", i < budget, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int saved;
    int i;
    rst = 0; write_time_req = 0;
    write_second = 0; write_minute = 0; write_hour = 0; write_date = 0;
    write_month = 0; write_week = 0; write_year = 0;
    rd_vals = '{8'h85, 8'h59, 8'h23, 8'h31, 8'h12, 8'h07, 8'h24};
    repeat (4) @(negedge clk);
    check("reset_ctrl", {write_time_ack, time_valid, busy, cmd_read, cmd_write,
                         read_addr, write_addr, write_data}, '0);
    check("reset_time", {read_second, read_minute, read_hour, read_date,
                         read_month, read_week, read_year}, '0);
    rst = 1;

    // First sweep right after reset, slow engine.
    wait_tv(1, 4000);
    check("first_second", read_second, 8'h05);
    check("first_year", read_year, 8'h24);

    // Plain time set from S_WAIT.
    ack_delay = 3;
    rd_vals = '{8'h12, 8'h34, 8'h11, 8'h05, 8'h06, 8'h03, 8'h26};
    drive_write(8'h30, 8'h15, 8'h08, 8'h01, 8'h01, 8'h01, 8'h25, 1);
    wait_ack(200);

    // Long first write transaction; CH bit of seconds must be dropped.
    ack_delay = 5000;
    drive_write(8'hD9, 8'h42, 8'h17, 8'h28, 8'h02, 8'h04, 8'h99, 1);
    for (i = 0; i < 1100 && !cmd_write; i++) @(negedge clk);
    check("long_start_timeout", cmd_write, 1);
    @(negedge clk);
    ack_delay = 3;
    wait_ack(6000);

    // Request mid-sweep, then an ignored second request while writing.
    for (i = 0; i < 3000 && !(cmd_read && eng_rd_idx == 3); i++) @(negedge clk);
    check("rd_idx3_timeout", i < 3000, 1);
    drive_write(8'h45, 8'h30, 8'h12, 8'h15, 8'h07, 8'h02, 8'h30, 1);
    wait_tv(1, 200);
    wait_wr_idx(2, 200);
    drive_write(8'h11, 8'h22, 8'h13, 8'h14, 8'h15, 8'h06, 8'h17, 0);
    wait_ack(200);

    // Idle sweeps: each gap is checked by the monitor.
    rd_vals = '{8'h59, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00};
    wait_tv(4, 6000);

    // Reset in the middle of write idx4.
    drive_write(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 1);
    wait_wr_idx(4, 2000);
    @(negedge clk);
    #2 rst = 0;
    wr_q.delete();
    ack_q.delete();
    #1;
    check("rst_mid_ctrl", {cmd_read, cmd_write, busy, write_time_ack, time_valid}, '0);
    check("rst_mid_time", {read_second, read_minute, read_hour, read_date,
                           read_month, read_week, read_year}, '0);
    saved = ack_cnt;
    repeat (2) @(negedge clk);
    rst = 1;
    wait_tv(1, 300);
    repeat (200) @(negedge clk);
    check("no_ack_after_rst", ack_cnt, saved);

    check("wr_q_empty", wr_q.size(), 0);
    check("snap_q_empty", snap_q.size(), 0);
    check("ack_q_empty", ack_q.size(), 0);
    check("cmd_exclusive", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
